// File: rtl/nina_pkg.sv
// nina_pkg: shared decode constants and enums for the NINA bank controller.
package nina_pkg;

    // CPU address decode: the high address bits select the register window,
    // bit 8 splits the window between the inner and ctrl registers.
    localparam int          ADDR_MSB     = 14;
    localparam logic [1:0]  INNER_HI_PAT = 2'b10;   // cpu_addr_in[14:13]
    localparam logic [2:0]  CTRL_HI_PAT  = 3'b101;  // cpu_addr_in[14:12]
    localparam int          SUB_BIT      = 8;       // 1 = inner, 0 = ctrl

    // Data field positions shared by the CPU and loader write paths.
    localparam int          BANK_W       = 4;       // data[3:0] -> bank
    localparam int          OUTER_W      = 3;       // data[2:0] -> outer
    localparam int          MIRROR_BIT   = 3;       // data[3]   -> mirror
    localparam int          LOCK_BIT     = 7;       // data[7]   -> locked

    // Loader handshake FSM.
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_ACK  = 2'd1,
        LD_DROP = 2'd2
    } ld_state_t;

    // Register most recently written by the CPU (consecutive-write filter).
    typedef enum logic [1:0] {
        REG_NONE  = 2'd0,
        REG_INNER = 2'd1,
        REG_CTRL  = 2'd2
    } reg_sel_t;

endpackage

// File: rtl/nina_bank_ctrl_if.sv
// nina_bank_ctrl_if: CPU bus, loader handshake and bank outputs of the controller.
//
// Loader handshake: ld_req is a level held by the loader until it sees a
// single-cycle ld_ack pulse; ld_sel/ld_data must stay stable while ld_req is
// high. After the ack the controller ignores ld_req until it has been seen
// low, so a request held high produces exactly one write.
interface nina_bank_ctrl_if;
    import nina_pkg::*;

    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        ld_req;
    logic        ld_sel;
    logic [7:0]  ld_data;
    logic        ld_ack;
    logic [3:0]  bank;
    logic [2:0]  outer;
    logic        mirror;
    logic        locked;
    // Debug visibility of the loader FSM and the deferral flag.
    ld_state_t   ld_state;
    logic        deferred;

    modport master (
        output romsel, cpu_rw_in, cpu_addr_in, cpu_data_in,
        output ld_req, ld_sel, ld_data,
        input  ld_ack, bank, outer, mirror, locked, ld_state, deferred
    );

    modport slave (
        input  romsel, cpu_rw_in, cpu_addr_in, cpu_data_in,
        input  ld_req, ld_sel, ld_data,
        output ld_ack, bank, outer, mirror, locked, ld_state, deferred
    );

endinterface

// File: rtl/nina_wr_decode.sv
// nina_wr_decode: CPU write decode with lock gating and the consecutive-write filter.
module nina_wr_decode
    import nina_pkg::*;
#(
    parameter bit RMW_FILTER = 1'b1
) (
    input  logic       m2,
    input  logic       rst,
    input  logic       romsel,
    input  logic       cpu_rw_in,
    input  logic [2:0] addr_hi,     // cpu_addr_in[14:12]
    input  logic       addr_sub,    // cpu_addr_in[8]
    input  logic       locked,
    input  logic       drop,        // loader owns this cycle, discard the CPU write
    output logic       inner_wr,
    output logic       ctrl_wr
);

    logic     cpu_wr;
    logic     inner_hit;
    logic     ctrl_hit;
    reg_sel_t last_reg;

    // Address decode; inner wins over ctrl so 0x5100-0x51FF is inner only.
    always_comb begin
        cpu_wr    = romsel & ~cpu_rw_in;
        inner_hit = cpu_wr & (addr_hi[2:1] == INNER_HI_PAT) & addr_sub;
        ctrl_hit  = cpu_wr & (addr_hi == CTRL_HI_PAT) & ~addr_sub & ~inner_hit;
        inner_wr  = inner_hit & ~drop & ~(RMW_FILTER && (last_reg == REG_INNER));
        ctrl_wr   = ctrl_hit & ~drop & ~locked & ~(RMW_FILTER && (last_reg == REG_CTRL));
    end

    // Remember which register was accepted this cycle; anything else clears it.
    always_ff @(negedge m2) begin
        if (rst) begin
            last_reg <= REG_NONE;
        end else if (inner_wr) begin
            last_reg <= REG_INNER;
        end else if (ctrl_wr) begin
            last_reg <= REG_CTRL;
        end else begin
            last_reg <= REG_NONE;
        end
    end

endmodule

// File: rtl/nina_bank_ctrl.sv
// nina_bank_ctrl: inner/outer bank registers written by the CPU or a loader.
// All state changes on the falling edge of m2.
module nina_bank_ctrl
    import nina_pkg::*;
#(
    parameter bit MIRRORING_VERTICAL = 1'b1,
    parameter bit RMW_FILTER         = 1'b1
) (
    input  logic            m2,
    input  logic            rst,
    nina_bank_ctrl_if.slave bus
);

    ld_state_t            state;
    ld_state_t            state_nx;
    logic                 deferred;
    logic                 ld_idle_req;
    logic                 drop_cpu;
    logic                 inner_wr;
    logic                 ctrl_wr;
    logic                 cpu_wr_eff;
    logic                 grant;
    logic                 defer_set;
    logic                 ld_ack_q;
    logic [BANK_W-1:0]    bank_q;
    logic [OUTER_W-1:0]   outer_q;
    logic                 mirror_q;
    logic                 locked_q;

    // A deferred loader request takes the cycle outright and kills the CPU write.
    always_comb begin
        ld_idle_req = (state == LD_IDLE) & bus.ld_req;
        drop_cpu    = ld_idle_req & deferred;
    end

    nina_wr_decode #(
        .RMW_FILTER (RMW_FILTER)
    ) u_wr_decode (
        .m2        (m2),
        .rst       (rst),
        .romsel    (bus.romsel),
        .cpu_rw_in (bus.cpu_rw_in),
        .addr_hi   (bus.cpu_addr_in[ADDR_MSB -: 3]),
        .addr_sub  (bus.cpu_addr_in[SUB_BIT]),
        .locked    (locked_q),
        .drop      (drop_cpu),
        .inner_wr  (inner_wr),
        .ctrl_wr   (ctrl_wr)
    );

    // Loader grant/deferral and next-state logic.
    always_comb begin
        cpu_wr_eff = inner_wr | ctrl_wr;
        grant      = ld_idle_req & (deferred | ~cpu_wr_eff);
        defer_set  = ld_idle_req & ~deferred & cpu_wr_eff;
        state_nx   = state;
        case (state)
            LD_IDLE: if (grant) state_nx = LD_ACK;
            LD_ACK:  state_nx = LD_DROP;
            LD_DROP: if (!bus.ld_req) state_nx = LD_IDLE;
            default: state_nx = LD_IDLE;
        endcase
    end

    // Loader FSM, ack pulse and deferral flag.
    always_ff @(negedge m2) begin
        if (rst) begin
            state    <= LD_IDLE;
            deferred <= 1'b0;
            ld_ack_q <= 1'b0;
        end else begin
            state    <= state_nx;
            ld_ack_q <= grant;
            if (grant) begin
                deferred <= 1'b0;
            end else if (defer_set) begin
                deferred <= 1'b1;
            end
        end
    end

    // Bank registers; a grant and an accepted CPU write never share a cycle.
    always_ff @(negedge m2) begin
        if (rst) begin
            bank_q   <= '0;
            outer_q  <= '0;
            mirror_q <= MIRRORING_VERTICAL;
            locked_q <= 1'b0;
        end else begin
            if (grant && !bus.ld_sel) begin
                bank_q <= bus.ld_data[BANK_W-1:0];
            end else if (inner_wr) begin
                bank_q <= bus.cpu_data_in[BANK_W-1:0];
            end
            if (grant && bus.ld_sel) begin
                outer_q  <= bus.ld_data[OUTER_W-1:0];
                mirror_q <= bus.ld_data[MIRROR_BIT];
                locked_q <= bus.ld_data[LOCK_BIT];
            end else if (ctrl_wr) begin
                outer_q  <= bus.cpu_data_in[OUTER_W-1:0];
                mirror_q <= bus.cpu_data_in[MIRROR_BIT];
                locked_q <= bus.cpu_data_in[LOCK_BIT];
            end
        end
    end

    assign bus.ld_ack   = ld_ack_q;
    assign bus.bank     = bank_q;
    assign bus.outer    = outer_q;
    assign bus.mirror   = mirror_q;
    assign bus.locked   = locked_q;
    assign bus.ld_state = state;
    assign bus.deferred = deferred;

endmodule

// File: doc/nina_bank_ctrl.md
NINA_BANK_CTRL -- requirements
Module: nina_bank_ctrl

Interface
REQ-001 SHALL have parameter MIRRORING_VERTICAL, default 1, reset value of mirror output.
REQ-002 SHALL have parameter RMW_FILTER, default 1; 1 enables the consecutive-write filter.
REQ-003 SHALL have port m2  in  1  sole clock; all state updates on falling edge of m2.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high, sampled on falling edge of m2.
REQ-005 SHALL have ports romsel, cpu_rw_in  in  1 each  CPU /ROMSEL and R/W (0 = write).
REQ-006 SHALL have ports cpu_addr_in[14:0], cpu_data_in[7:0]  in  CPU address and data.
REQ-007 SHALL have port ld_req  in  1  loader request, level, held until acknowledged.
REQ-008 SHALL have port ld_sel  in  1  loader target: 0 = inner, 1 = outer/ctrl.
REQ-009 SHALL have port ld_data  in  8  loader write data.
REQ-010 SHALL have port ld_ack  out  1  one-cycle pulse, loader write committed.
REQ-011 SHALL have port bank  out  4  inner bank (bank[3] PRG 32K, bank[2:0] CHR 8K).
REQ-012 SHALL have port outer  out  3  outer (multicart) bank.
REQ-013 SHALL have ports mirror, locked  out  1 each  mirroring select and lock status.

Function
REQ-014 SHALL decode a CPU inner write when romsel=1, cpu_rw_in=0, cpu_addr_in[14:13]=2'b10, cpu_addr_in[8]=1: bank <= data[3:0].
REQ-015 SHALL decode a CPU ctrl write when romsel=1, cpu_rw_in=0, cpu_addr_in[14:12]=3'b101, cpu_addr_in[8]=0: outer <= data[2:0], mirror <= data[3], locked <= data[7].
REQ-016 SHALL, when a ctrl write targets addresses 0x5100-0x51FF, treat it as an inner write only (REQ-014 takes precedence).
REQ-017 SHALL ignore CPU ctrl writes while locked=1; CPU inner writes remain effective.
REQ-018 SHALL, with RMW_FILTER=1, ignore a CPU write to the same register as the CPU write accepted in the immediately preceding cycle; a non-write cycle clears the filter.
REQ-019 SHALL implement loader FSM states IDLE, ACK, DROP. IDLE->ACK on commit, ACK->DROP unconditionally, DROP->IDLE when ld_req=0.
REQ-020 SHALL commit a loader write in IDLE when ld_req=1 and the grant rule allows it: ld_sel=0 sets bank <= ld_data[3:0]; ld_sel=1 sets outer, mirror and locked as in REQ-015. The lock is ignored for loader writes.
REQ-021 SHALL assert ld_ack for exactly the cycle after commit, in state ACK.
REQ-022 SHALL give the CPU priority when a CPU write and a loader request occur in the same cycle, and set a deferred flag.
REQ-023 SHALL grant the loader unconditionally in the cycle after a deferral; a CPU write in that cycle is dropped; the deferred flag clears on grant.
REQ-024 SHALL make outputs directly registered, with updates visible on the edge following the write cycle (latency 1 edge).
REQ-025 SHALL not commit a loader request in ACK or DROP; a request held high produces exactly one write.

Reset
REQ-026 SHALL, when rst=1, set bank=0, outer=0, mirror=MIRRORING_VERTICAL, locked=0, ld_ack=0, FSM=IDLE, deferred=0, filter cleared.
REQ-027 SHALL give rst priority over every simultaneous CPU or loader write; a loader request pending at reset is re-acknowledged after reset only if ld_req is still high.

Structure
REQ-028 SHALL place the decode constants (address match patterns, field bit positions) and the FSM state enum in shared package nina_pkg.
REQ-029 SHALL contain one sub-module, nina_wr_decode (combinational CPU write decode plus RMW filter register); all other logic is inline.

Verification
REQ-030 SHALL cover: CPU write 0x0B at 0x4100 -> bank=0xB next edge; CPU write 0x8D at 0x5000 -> outer=5, mirror=1, locked=1.
REQ-031 SHALL cover: locked=1, CPU write 0x03 at 0x5000 -> outer unchanged; CPU write 0x02 at 0x4100 -> bank=2.
REQ-032 SHALL cover: RMW_FILTER=1, writes 0x05 then 0x06 at 0x4100 in consecutive cycles -> bank=5; with an idle cycle between -> bank=6.
REQ-033 SHALL cover: ld_req=1, ld_sel=1, ld_data=0x07 simultaneous with a CPU inner write 0x01 -> bank=1, then loader commit next cycle (outer=7, locked=0), ld_ack a single pulse, ld_req held 10 cycles -> no second ack.
REQ-034 SHALL cover: rst asserted in the same cycle as a CPU write 0x0F at 0x4100 -> bank=0, mirror=MIRRORING_VERTICAL, ld_ack=0.
